// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the health-calculation execution controller:
//   - state_t      : controller FSM states
//   - BMI_SCALE    : dividend scale for the integer BMI quotient
//   - BMR_*        : Mifflin-St Jeor style BMR coefficients and offsets
//   - bmr_calc()   : one-step BMR arithmetic, 32-bit two's complement result
// -----------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    DIV  = 3'd2,
    BMR  = 3'd3,
    WB   = 3'd4
  } state_t;

  localparam int unsigned BMI_SCALE = 10000;

  localparam int BMR_W_COEF     = 10;
  localparam int BMR_H_COEF     = 25;
  localparam int BMR_H_SHIFT    = 2;
  localparam int BMR_AGE_COEF   = 5;
  localparam int BMR_MALE_OFS   = 5;
  localparam int BMR_FEMALE_OFS = -161;

  // 10*w + ((25*h)>>2) - 5*age + ofs. Computed modulo 2^32, so the returned
  // bit pattern is the signed two's complement result; operands are
  // zero-extended measurements, so no intermediate overflows.
  function automatic logic [31:0] bmr_calc(input logic [31:0] w,
                                           input logic [31:0] h,
                                           input logic        male,
                                           input logic [5:0]  age);
    logic [31:0] pos;
    logic [31:0] neg;
    logic [31:0] ofs;
    pos = w * 32'(BMR_W_COEF) + ((h * 32'(BMR_H_COEF)) >> BMR_H_SHIFT);
    neg = {26'd0, age} * 32'(BMR_AGE_COEF);
    ofs = male ? 32'(BMR_MALE_OFS) : 32'(BMR_FEMALE_OFS);
    return pos - neg + ofs;
  endfunction

endpackage

// File: rtl/calc_exec_ctrl_if.sv
// -----------------------------------------------------------------------------
// calc_exec_ctrl_if
// Instruction and result handshakes of the calc execution controller.
//   Instruction side : in_valid/in_ready, is_set_height, is_set_weight,
//                      is_calc_bmi, is_calc_bmr, funct7, rs1_data, rd
//   Result side      : res_valid/res_ready, res_rd, res_data, res_err
//   Status           : busy
// master = decode/writeback side, slave = the controller.
// -----------------------------------------------------------------------------
interface calc_exec_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              is_set_height;
  logic              is_set_weight;
  logic              is_calc_bmi;
  logic              is_calc_bmr;
  logic [6:0]        funct7;
  logic [DATA_W-1:0] rs1_data;
  logic [4:0]        rd;

  logic              res_valid;
  logic              res_ready;
  logic [4:0]        res_rd;
  logic [DATA_W-1:0] res_data;
  logic              res_err;

  logic              busy;

  modport master (
    output in_valid, is_set_height, is_set_weight, is_calc_bmi, is_calc_bmr,
    output funct7, rs1_data, rd, res_ready,
    input  in_ready, res_valid, res_rd, res_data, res_err, busy
  );

  modport slave (
    input  in_valid, is_set_height, is_set_weight, is_calc_bmi, is_calc_bmr,
    input  funct7, rs1_data, rd, res_ready,
    output in_ready, res_valid, res_rd, res_data, res_err, busy
  );
endinterface

// File: rtl/calc_exec_ctrl_div.sv
// -----------------------------------------------------------------------------
// calc_div_seq
// Unsigned restoring divider, one quotient bit per cycle.
//   clk, rst     : clock, asynchronous active-high reset
//   i_start      : 1-cycle pulse, captures i_dividend / i_divisor
//   i_dividend   : W-bit dividend
//   i_divisor    : W-bit divisor (must be non-zero)
//   o_done       : 1-cycle pulse, W cycles after i_start
//   o_quotient   : valid while o_done is high
// o_quotient is the combinational result of the final iteration, so the
// caller can register it on the same edge the divider retires.
// -----------------------------------------------------------------------------
module calc_div_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_done,
  output logic [W-1:0] o_quotient
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_quo;
  logic [W-1:0]     r_div;
  logic [CNT_W-1:0] r_cnt;

  logic [W:0]       w_rem_shift;
  logic [W:0]       w_diff;
  logic             w_fit;
  logic [W-1:0]     w_rem_nxt;
  logic [W-1:0]     w_quo_nxt;

  // Shift the next dividend bit into the partial remainder and try the
  // subtraction; bit W of the difference is the borrow (did not fit).
  always_comb begin
    w_rem_shift = {r_rem, r_quo[W-1]};
    w_diff      = w_rem_shift - {1'b0, r_div};
    w_fit       = ~w_diff[W];
    w_rem_nxt   = w_fit ? w_diff[W-1:0] : w_rem_shift[W-1:0];
    w_quo_nxt   = {r_quo[W-2:0], w_fit};
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_div <= i_divisor;
      r_cnt <= CNT_W'(W);
    end else if (r_cnt != '0) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done     = (r_cnt == CNT_W'(1));
  assign o_quotient = w_quo_nxt;

endmodule

// File: rtl/calc_exec_ctrl.sv
// -----------------------------------------------------------------------------
// calc_exec_ctrl
// Execution controller for the custom health-calculation instructions.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : calc_exec_ctrl_if.slave
//          - decoded instruction in (in_valid/in_ready, flags, funct7,
//            rs1_data, rd)
//          - one result per calc instruction out (res_valid/res_ready,
//            res_rd, res_data, res_err), busy = not IDLE
// set_height / set_weight complete in IDLE at the accept edge. calc_bmi
// squares the height, scales the weight and runs the shared iterative
// divider; calc_bmr is a single arithmetic step. Results wait in WB until
// writeback takes them.
// -----------------------------------------------------------------------------
module calc_exec_ctrl
  import calc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MEAS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  calc_exec_ctrl_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [MEAS_W-1:0] r_height;
  logic [MEAS_W-1:0] r_weight;
  logic [4:0]        r_rd;
  logic [6:0]        r_funct7;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_err;

  logic              w_accept;
  logic              w_height_zero;
  logic [DATA_W-1:0] w_h_ext;
  logic [DATA_W-1:0] w_w_ext;
  logic [DATA_W-1:0] w_divisor;
  logic [DATA_W-1:0] w_dividend;
  logic [DATA_W-1:0] w_bmr;
  logic              w_div_start;
  logic              w_div_done;
  logic [DATA_W-1:0] w_div_quo;
  logic              w_unused_rs1;

  // Only the low MEAS_W bits of rs1 carry a measurement.
  assign w_unused_rs1 = ^bus.rs1_data[DATA_W-1:MEAS_W];

  assign w_accept      = bus.in_valid && (r_state == IDLE);
  assign w_height_zero = (r_height == '0);
  assign w_h_ext       = {{(DATA_W-MEAS_W){1'b0}}, r_height};
  assign w_w_ext       = {{(DATA_W-MEAS_W){1'b0}}, r_weight};
  assign w_divisor     = w_h_ext * w_h_ext;
  assign w_dividend    = w_w_ext * DATA_W'(BMI_SCALE);
  assign w_bmr         = bmr_calc(w_w_ext, w_h_ext, r_funct7[6], r_funct7[5:0]);

  calc_div_seq #(
    .W (DATA_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_done     (w_div_done),
    .o_quotient (w_div_quo)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. Set flags outrank calc flags, so a set never leaves
  // IDLE; with no flag high the instruction is swallowed as a NOP.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.in_valid && !bus.is_set_height && !bus.is_set_weight) begin
          if (bus.is_calc_bmi)      w_state_nxt = SQ;
          else if (bus.is_calc_bmr) w_state_nxt = BMR;
        end
      end
      SQ:      w_state_nxt = w_height_zero ? WB : DIV;
      DIV:     if (w_div_done) w_state_nxt = WB;
      BMR:     w_state_nxt = WB;
      WB:      if (bus.res_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.busy      = (r_state != IDLE);
    bus.res_valid = (r_state == WB);
    w_div_start   = (r_state == SQ) && !w_height_zero;
  end

  assign bus.res_rd   = r_rd;
  assign bus.res_data = r_res_data;
  assign bus.res_err  = r_res_err;

  // Measurement registers, calc context and result registers. Sets are only
  // accepted in IDLE, so height/weight cannot change under a running calc,
  // and rd/funct7 stay put until the result has been handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_height   <= '0;
      r_weight   <= '0;
      r_rd       <= '0;
      r_funct7   <= '0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (bus.is_set_height) begin
          r_height <= bus.rs1_data[MEAS_W-1:0];
        end else if (bus.is_set_weight) begin
          r_weight <= bus.rs1_data[MEAS_W-1:0];
        end else if (bus.is_calc_bmi || bus.is_calc_bmr) begin
          r_rd     <= bus.rd;
          r_funct7 <= bus.funct7;
        end
      end

      case (r_state)
        SQ: begin
          if (w_height_zero) begin
            r_res_data <= '0;
            r_res_err  <= 1'b1;
          end
        end
        DIV: begin
          if (w_div_done) begin
            r_res_data <= w_div_quo;
            r_res_err  <= 1'b0;
          end
        end
        BMR: begin
          r_res_data <= w_bmr;
          r_res_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calc_exec_ctrl
// Directed vectors for calc_exec_ctrl. The driver pushes the hand-computed
// expected result (rd, data, err, latency) into a scoreboard when a calc is
// accepted; an independent monitor compares every cycle res_valid is high.
// -----------------------------------------------------------------------------
module tb_calc_exec_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  calc_exec_ctrl_if #(.DATA_W(32)) bus ();

  calc_exec_ctrl #(
    .DATA_W (32),
    .MEAS_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_SH   = 4'b1000;
  localparam logic [3:0] F_SW   = 4'b0100;
  localparam logic [3:0] F_BMI  = 4'b0010;
  localparam logic [3:0] F_BMR  = 4'b0001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    bus.in_valid      = 1'b0;
    bus.is_set_height = 1'b0;
    bus.is_set_weight = 1'b0;
    bus.is_calc_bmi   = 1'b0;
    bus.is_calc_bmr   = 1'b0;
    bus.funct7        = '0;
    bus.rs1_data      = '0;
    bus.rd            = '0;
  endtask

  task automatic drive(input logic [3:0] fl, input logic [6:0] f7,
                       input logic [31:0] rs1, input logic [4:0] rd);
    bus.in_valid      = 1'b1;
    bus.is_set_height = fl[3];
    bus.is_set_weight = fl[2];
    bus.is_calc_bmi   = fl[1];
    bus.is_calc_bmr   = fl[0];
    bus.funct7        = f7;
    bus.rs1_data      = rs1;
    bus.rd            = rd;
  endtask

  // Entered and left one time unit after a rising edge. acc is the cycle
  // number of the accept cycle T0.
  task automatic issue(input logic [3:0] fl, input logic [6:0] f7,
                       input logic [31:0] rs1, input logic [4:0] rd, output int acc);
    drive(fl, f7, rs1, rd);
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic expect_res(input logic [4:0] rd, input logic [31:0] data,
                            input logic err, input int lat, input int acc);
    exp_t e;
    e.rd = rd; e.data = data; e.err = err; e.lat = lat; e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit done_ok;
    done_ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.in_ready) begin
        done_ok = 1'b1;
        break;
      end
    end
    if (!done_ok) check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: first valid cycle checks latency, every valid cycle checks the
  // payload (which also proves it is held while res_ready is low).
  initial begin
    bit prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.res_valid) begin
        if (sb.size() == 0) begin
          check("spurious_res_valid", {31'd0, bus.res_valid}, 32'd0);
        end else begin
          if (!prev_valid) check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          check("res_rd",   {27'd0, bus.res_rd}, {27'd0, sb[0].rd});
          check("res_data", bus.res_data, sb[0].data);
          check("res_err",  {31'd0, bus.res_err}, {31'd0, sb[0].err});
          if (bus.res_ready) void'(sb.pop_front());
        end
      end
      prev_valid = bus.res_valid && !bus.res_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, acc;
    clear_inputs();
    bus.res_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_res_data",  bus.res_data, 32'd0);
    check("rst_res_rd",    {27'd0, bus.res_rd}, 32'd0);
    check("rst_res_err",   {31'd0, bus.res_err}, 32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    check("rst_busy",      {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // BMI with height 0 straight after reset: error result at T0+2
    issue(F_BMI, 7'h00, 32'd0, 5'd1, acc);
    expect_res(5'd1, 32'd0, 1'b1, 2, acc);
    wait_idle();

    // Back-to-back sets, then BMI: 75*10000/(180*180) = 23 at T0+34
    issue(F_SH, 7'h00, 32'd180, 5'd0, a0);
    issue(F_SW, 7'h00, 32'd75, 5'd0, a1);
    check("set_back_to_back", 32'(a1 - a0), 32'd1);
    issue(F_BMI, 7'h00, 32'd0, 5'd5, acc);
    expect_res(5'd5, 32'd23, 1'b0, 34, acc);
    wait_idle();

    // BMR male age 30: 750 + 1125 - 150 + 5 = 1730
    issue(F_BMR, 7'h5E, 32'd0, 5'd6, acc);
    expect_res(5'd6, 32'd1730, 1'b0, 2, acc);
    wait_idle();

    // BMR female age 25, h=165 w=60: 600 + 1031 - 125 - 161 = 1345
    issue(F_SH, 7'h00, 32'd165, 5'd0, acc);
    issue(F_SW, 7'h00, 32'd60, 5'd0, acc);
    issue(F_BMR, 7'h19, 32'd0, 5'd7, acc);
    expect_res(5'd7, 32'd1345, 1'b0, 2, acc);
    wait_idle();

    // Backpressure: result held 5 cycles, set_weight(90) stalled behind it.
    // Male age 40 with old weight 60: 600 + 1031 - 200 + 5 = 1436
    bus.res_ready = 1'b0;
    issue(F_BMR, 7'h68, 32'd0, 5'd8, acc);
    expect_res(5'd8, 32'd1436, 1'b0, 2, acc);
    drive(F_SW, 7'h00, 32'd90, 5'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    @(negedge clk);
    check("handshake_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("set_after_handshake", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 clear_inputs();

    // New weight now visible: 900 + 1031 - 200 + 5 = 1736
    issue(F_BMR, 7'h68, 32'd0, 5'd9, acc);
    expect_res(5'd9, 32'd1736, 1'b0, 2, acc);
    wait_idle();

    // BMI 90*10000/27225 = 33
    issue(F_BMI, 7'h00, 32'd0, 5'd10, acc);
    expect_res(5'd10, 32'd33, 1'b0, 34, acc);
    wait_idle();

    // set_height outranks calc_bmi: loads 170, no result
    issue(F_SH | F_BMI, 7'h00, 32'd170, 5'd3, acc);
    @(negedge clk);
    check("prio_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    // No flags: accepted as NOP
    issue(F_NONE, 7'h00, 32'd999, 5'd4, acc);
    @(negedge clk);
    check("nop_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    // h=170 w=90 female age 20: 900 + 1062 - 100 - 161 = 1701
    issue(F_BMR, 7'h14, 32'd0, 5'd11, acc);
    expect_res(5'd11, 32'd1701, 1'b0, 2, acc);
    wait_idle();

    // Reset at T0+10 of a BMI: aborted, no result
    issue(F_BMI, 7'h00, 32'd0, 5'd12, acc);
    for (int i = 0; i < 20 && cyc < acc + 10; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("abort_busy",      {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (40) @(posedge clk);
    #1;

    // Measurements cleared: male age 0 -> 5, female age 0 -> -161
    issue(F_BMR, 7'h40, 32'd0, 5'd13, acc);
    expect_res(5'd13, 32'd5, 1'b0, 2, acc);
    wait_idle();
    issue(F_BMR, 7'h00, 32'd0, 5'd15, acc);
    expect_res(5'd15, 32'hFFFF_FF5F, 1'b0, 2, acc);
    wait_idle();
    issue(F_BMI, 7'h00, 32'd0, 5'd14, acc);
    expect_res(5'd14, 32'd0, 1'b1, 2, acc);
    wait_idle();

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/calc_exec_ctrl.md
Name: calc_exec_ctrl

Overview:
Execution controller for the custom health-calculation instructions.
- Accepts already-decoded flags (set_height, set_weight, calc_bmi, calc_bmr) with a valid/ready handshake.
- Holds the height and weight state registers.
- Sequences a shared iterative divider for BMI and a one-cycle arithmetic step for BMR.
- Returns one result per calc instruction to writeback over a second valid/ready handshake.

Parameters:
- DATA_W, 32, width of rs1_data and res_data.
- MEAS_W, 16, width of the stored height (cm) and weight (kg); taken from rs1_data[MEAS_W-1:0].
- BMI_SCALE, 10000, dividend scale, so BMI = weight*BMI_SCALE/(height*height), integer.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  controller can accept.
- is_set_height  in  1  decoded flag.
- is_set_weight  in  1  decoded flag.
- is_calc_bmi  in  1  decoded flag.
- is_calc_bmr  in  1  decoded flag.
- funct7  in  7  [6] gender (1 = male, 0 = female); [5:0] age in years.
- rs1_data  in  DATA_W  operand for set_height / set_weight.
- rd  in  5  destination register of a calc instruction.
- res_valid  out  1  result available.
- res_ready  in  1  writeback accepts result.
- res_rd  out  5  destination register of the result.
- res_data  out  DATA_W  result: BMI unsigned, BMR signed two's complement.
- res_err  out  1  result is invalid (BMI with height = 0).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE; height_q=0, weight_q=0; res_valid=0, res_data=0, res_rd=0, res_err=0. Reset mid-operation aborts it; no result is produced.
- in_ready = (state==IDLE). Acceptance happens on an edge where in_valid && in_ready; call the accept cycle T0.
- Flag priority when several flags are high: set_height > set_weight > calc_bmi > calc_bmr. If none is high, the instruction is accepted and dropped (NOP).
- set_height / set_weight: the register loads rs1_data[MEAS_W-1:0] at the T0 edge. State stays IDLE and no result is produced, so back-to-back sets are accepted every cycle.
- calc instructions latch rd and funct7 at T0.
- FSM states: IDLE, SQ, DIV, BMR, WB.
  - IDLE -> SQ on calc_bmi.
  - IDLE -> BMR on calc_bmr.
  - SQ (cycle T0+1): divisor = height_q*height_q (32-bit); dividend = weight_q*BMI_SCALE (32-bit).
    - height_q==0: set res_err=1, res_data=0, go to WB.
    - otherwise: pulse div start, go to DIV.
  - DIV (cycles T0+2 .. T0+33): the restoring divider runs 32 cycles, 1 quotient bit per cycle. On div done: res_data = quotient, res_err = 0, go to WB.
  - BMR (cycle T0+1): res_data = 10*w + ((25*h)>>2) - 5*age + (male ? 5 : -161). Computed in signed 32-bit, with w = weight_q, h = height_q (zero-extended), age = funct7[5:0]. Then go to WB.
  - WB: res_valid=1; res_rd, res_data and res_err are held stable while res_ready=0. On res_valid && res_ready, go to IDLE and clear res_valid on the next edge.
- Latency, accept to first res_valid cycle:
  - BMI (height != 0): T0+34.
  - BMI (height = 0): T0+2.
  - BMR: T0+2.
- A set instruction arriving during a calc is stalled (in_ready=0). The calc always uses height and weight as they were at T0.
- height_q and weight_q are not modified by calc instructions.
- Arithmetic needs no overflow checks: with 16-bit measurements, every intermediate fits in 32 bits.

Decomposition:
- Shared package calc_pkg:
  - state enum {IDLE, SQ, DIV, BMR, WB}
  - BMI_SCALE
  - BMR_MALE_OFS = 5, BMR_FEMALE_OFS = -161
  - BMR coefficients 10, 25 (shift 2), 5
- Sub-module calc_div_seq: 32-bit unsigned restoring divider.
  - Ports: clk, rst, start, dividend, divisor, done (1-cycle pulse), quotient.
  - done fires 32 cycles after start.

Test Plan:
1. set_height rs1=180 then set_weight rs1=75 on consecutive cycles, then calc_bmi rd=5 -> res_valid first high at T0+34; res_data=23, res_rd=5, res_err=0.
2. Same state, calc_bmr funct7={1,30} rd=6 -> res_data=1730 at T0+2. Then h=165, w=60, funct7={0,25} -> res_data=1345.
3. After reset (height_q=0), calc_bmi -> res_valid at T0+2, res_data=0, res_err=1.
4. calc_bmr with res_ready held low 5 cycles while a set_weight waits with in_valid=1:
   - res_* stays stable and in_ready stays 0;
   - set_weight is accepted the cycle after the result handshake;
   - the computed result used the old weight.
5. in_valid with is_set_height=is_calc_bmi=1, rs1=170 -> height_q=170 and no result produced. With all flags 0 -> accepted, no state change.
6. Assert rst at T0+10 of a BMI -> res_valid=0 and height_q=weight_q=0 immediately. in_ready=1 after release; no stale result appears.
